// File: rtl/systolic_pkg.sv
// Shared types and elaboration helpers for the weight-stationary systolic engine.
package systolic_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int lat(input int size);
    return 2 * size;
  endfunction

  // Accumulator must hold a full product plus growth over SIZE terms.
  function automatic bit acc_w_ok(input int data_w, input int acc_w, input int size);
    return acc_w >= (2 * data_w + clog2(size));
  endfunction

endpackage

// File: rtl/systolic_ws_if.sv
// Weight, activation and result streams of systolic_ws; the master drives weights/activations.
interface systolic_ws_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int SIZE   = 3
);
  logic                     w_valid;
  logic                     w_ready;
  logic [DATA_W*SIZE-1:0]   w_stream;
  logic                     a_valid;
  logic                     a_ready;
  logic [DATA_W*SIZE-1:0]   a_stream;
  logic                     y_valid;
  logic [ACC_W*SIZE-1:0]    y_stream;

  modport master (
    output w_valid, w_stream, a_valid, a_stream,
    input  w_ready, a_ready, y_valid, y_stream
  );

  modport slave (
    input  w_valid, w_stream, a_valid, a_stream,
    output w_ready, a_ready, y_valid, y_stream
  );
endinterface

// File: rtl/systolic_pe.sv
// One processing element: stationary weight, forwarded activation, accumulated partial sum.
// Build option: SYSTOLIC_SIGNED_EN selects two's-complement operands (default unsigned).
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [DATA_W-1:0] w_in,
  input  logic [DATA_W-1:0] a_in,
  input  logic [ACC_W-1:0]  sum_in,
  output logic [DATA_W-1:0] a_out,
  output logic [ACC_W-1:0]  sum_out
);
  logic [DATA_W-1:0] w_q, w_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [ACC_W-1:0]  sum_q, sum_d;
  logic [ACC_W-1:0]  prod_ext;

`ifdef SYSTOLIC_SIGNED_EN
  logic signed [2*DATA_W-1:0] prod;
  assign prod = $signed({{DATA_W{a_in[DATA_W-1]}}, a_in}) * $signed({{DATA_W{w_q[DATA_W-1]}}, w_q});
`else
  logic [2*DATA_W-1:0] prod;
  assign prod = {{DATA_W{1'b0}}, a_in} * {{DATA_W{1'b0}}, w_q};
`endif
  assign prod_ext = ACC_W'(prod);

  always_comb begin
    if (we) begin
      w_d = w_in;
    end else begin
      w_d = w_q;
    end
    a_d   = a_in;
    sum_d = sum_in + prod_ext;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_q   <= '0;
      a_q   <= '0;
      sum_q <= '0;
    end else begin
      w_q   <= w_d;
      a_q   <= a_d;
      sum_q <= sum_d;
    end
  end

  assign a_out   = a_q;
  assign sum_out = sum_q;
endmodule

// File: rtl/systolic_ws_chk.sv
// Elaboration-time legality check of the systolic_ws parameter set.
module systolic_ws_chk
  import systolic_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int SIZE   = 3
) ();
  if (!acc_w_ok(DATA_W, ACC_W, SIZE)) begin : g_bad_acc_w
    $error("systolic_ws: ACC_W=%0d too narrow for DATA_W=%0d SIZE=%0d", ACC_W, DATA_W, SIZE);
  end
endmodule

// File: rtl/systolic_ws.sv
// Weight-stationary SIZE x SIZE matrix-vector engine, y = a*W, fixed latency 2*SIZE.
// Build option: SYSTOLIC_SIGNED_EN selects two's-complement operands (default unsigned).
module systolic_ws
  import systolic_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int SIZE   = 3
) (
  input logic          clk,
  input logic          rst_n,
  systolic_ws_if.slave bus
);
  localparam int LAT   = lat(SIZE);
  localparam int CNT_W = clog2(2 * SIZE + 1);
  localparam int K_W   = (SIZE > 1) ? clog2(SIZE) : 1;

  state_e                 state_q, state_d;
  logic [K_W-1:0]         k_q, k_d;
  logic [CNT_W-1:0]       inflight_q, inflight_d;
  logic [LAT-2:0]         vld_q, vld_d;
  logic                   y_valid_q, y_valid_d;
  logic [ACC_W*SIZE-1:0]  y_stream_q, y_stream_d;
  logic [ACC_W*SIZE-1:0]  y_flat;
  logic                   w_acc, a_acc;

  logic [DATA_W-1:0] a_in_s   [SIZE];
  logic [DATA_W-1:0] a_link   [SIZE][SIZE+1];
  logic [ACC_W-1:0]  sum_link [SIZE+1][SIZE];
  logic [ACC_W-1:0]  desk     [SIZE];

  systolic_ws_chk #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SIZE(SIZE)) u_chk ();

  // Weight writes only with an empty pipeline; any pending reload starves new vectors.
  assign bus.w_ready = (state_q == LOAD) || (inflight_q == '0);
  assign bus.a_ready = (state_q == READY) && !bus.w_valid;
  assign w_acc       = bus.w_valid && bus.w_ready;
  assign a_acc       = bus.a_valid && bus.a_ready;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    inflight_d = inflight_q;
    case (state_q)
      EMPTY, LOAD, READY: begin
        if (w_acc && (k_q == K_W'(SIZE - 1))) begin
          state_d = READY;
          k_d     = '0;
        end else if (w_acc) begin
          state_d = LOAD;
          k_d     = k_q + K_W'(1);
        end else begin
          state_d = state_q;
          k_d     = k_q;
        end
      end
      default: begin
        state_d = EMPTY;
        k_d     = '0;
      end
    endcase
    case ({a_acc, y_valid_q})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
    vld_d[0] = a_acc;
    for (int i = 1; i < LAT - 1; i++) vld_d[i] = vld_q[i-1];
    y_valid_d = vld_q[LAT-2];
    if (vld_q[LAT-2]) begin
      y_stream_d = y_flat;
    end else begin
      y_stream_d = y_stream_q;
    end
  end

  // Idle cycles inject zeros so only accepted vectors ever reach the accumulators.
  always_comb begin
    y_flat = '0;
    for (int r = 0; r < SIZE; r++) begin
      if (a_acc) begin
        a_in_s[r] = bus.a_stream[(SIZE-r)*DATA_W-1 -: DATA_W];
      end else begin
        a_in_s[r] = '0;
      end
    end
    for (int c = 0; c < SIZE; c++) y_flat[(SIZE-c)*ACC_W-1 -: ACC_W] = desk[c];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      k_q        <= '0;
      inflight_q <= '0;
      vld_q      <= '0;
      y_valid_q  <= 1'b0;
      y_stream_q <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      inflight_q <= inflight_d;
      vld_q      <= vld_d;
      y_valid_q  <= y_valid_d;
      y_stream_q <= y_stream_d;
    end
  end

  for (genvar r = 0; r < SIZE; r++) begin : g_skew
    if (r == 0) begin : g_direct
      assign a_link[0][0] = a_in_s[0];
    end else begin : g_dly
      logic [DATA_W-1:0] sk_q [r];
      logic [DATA_W-1:0] sk_d [r];
      always_comb begin
        sk_d[0] = a_in_s[r];
        for (int i = 1; i < r; i++) sk_d[i] = sk_q[i-1];
      end
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < r; i++) sk_q[i] <= '0;
        end else begin
          sk_q <= sk_d;
        end
      end
      assign a_link[r][0] = sk_q[r-1];
    end
  end

  for (genvar c = 0; c < SIZE; c++) begin : g_col
    assign sum_link[0][c] = '0;
    if (c == SIZE - 1) begin : g_direct
      assign desk[c] = sum_link[SIZE][c];
    end else begin : g_dly
      logic [ACC_W-1:0] dk_q [SIZE-1-c];
      logic [ACC_W-1:0] dk_d [SIZE-1-c];
      always_comb begin
        dk_d[0] = sum_link[SIZE][c];
        for (int i = 1; i < SIZE - 1 - c; i++) dk_d[i] = dk_q[i-1];
      end
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < SIZE - 1 - c; i++) dk_q[i] <= '0;
        end else begin
          dk_q <= dk_d;
        end
      end
      assign desk[c] = dk_q[SIZE-2-c];
    end
  end

  for (genvar r = 0; r < SIZE; r++) begin : g_pe_row
    for (genvar c = 0; c < SIZE; c++) begin : g_pe_col
      systolic_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (w_acc && (k_q == K_W'(r))),
        .w_in    (bus.w_stream[(SIZE-c)*DATA_W-1 -: DATA_W]),
        .a_in    (a_link[r][c]),
        .sum_in  (sum_link[r][c]),
        .a_out   (a_link[r][c+1]),
        .sum_out (sum_link[r+1][c])
      );
    end
  end

  assign bus.y_valid  = y_valid_q;
  assign bus.y_stream = y_stream_q;
endmodule

// File: tb/tb_systolic_ws.sv
// Self-checking bench for systolic_ws (SIZE=3, DATA_W=8, ACC_W=24) with a matrix-product model.
module tb_systolic_ws;
  localparam int D   = 8;
  localparam int A   = 24;
  localparam int S   = 3;
  localparam int LAT = 2 * S;
  localparam int VW  = D * S;
  localparam int YW  = A * S;

  typedef struct { int cyc; logic [YW-1:0] y; } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   wm [S][S];
  logic [VW-1:0] w_rows [S];
  ev_t  exp_q[$];
  ev_t  obs_q[$];

  systolic_ws_if #(.DATA_W(D), .ACC_W(A), .SIZE(S)) bus ();
  systolic_ws #(.DATA_W(D), .ACC_W(A), .SIZE(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.y_valid === 1'b1) obs_q.push_back('{cyc, bus.y_stream});

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got time=%0t want below 400000", $time);
    $fatal(1);
  end

  function automatic logic [VW-1:0] pack3(input int e0, input int e1, input int e2);
    return {D'(e0), D'(e1), D'(e2)};
  endfunction

  function automatic logic [YW-1:0] ypack3(input int e0, input int e1, input int e2);
    return {A'(e0), A'(e1), A'(e2)};
  endfunction

  // y[c] = sum_r a[r]*W[r][c], reduced modulo 2^ACC_W.
  function automatic logic [YW-1:0] ref_y(input logic [VW-1:0] a);
    logic [YW-1:0] y;
    longint acc;
    int av, wv;
    y = '0;
    for (int c = 0; c < S; c++) begin
      acc = 0;
      for (int r = 0; r < S; r++) begin
        av = int'(a[(S-r)*D-1 -: D]);
        wv = wm[r][c];
`ifdef SYSTOLIC_SIGNED_EN
        if (av >= (1 << (D-1))) av = av - (1 << D);
        if (wv >= (1 << (D-1))) wv = wv - (1 << D);
`endif
        acc = acc + longint'(av) * longint'(wv);
      end
      y[(S-c)*A-1 -: A] = acc[A-1:0];
    end
    return y;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_w();
    int n;
    for (int k = 0; k < S; k++) begin
      bus.w_valid  = 1'b1;
      bus.w_stream = w_rows[k];
      #1;
      n = 0;
      while (bus.w_ready !== 1'b1 && n < 50) begin
        step(1);
        n++;
      end
      if (n >= 50) begin
        total++; bad++;
        $display("FAIL load_timeout row=%0d got w_ready=%b want 1 within 50 cycles", k, bus.w_ready);
      end
      step(1);
    end
    bus.w_valid = 1'b0;
    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++) wm[r][c] = int'(w_rows[r][(S-c)*D-1 -: D]);
  endtask

  task automatic send_vec(input logic [VW-1:0] v, input logic [YW-1:0] want, output bit acc);
    bus.a_valid  = 1'b1;
    bus.a_stream = v;
    #1;
    acc = (bus.a_ready === 1'b1);
    step(1);
    bus.a_valid = 1'b0;
    if (acc) exp_q.push_back('{cyc + LAT - 1, want});
  endtask

  task automatic test_reset();
    bus.w_valid = 1'b0; bus.w_stream = '0; bus.a_valid = 1'b1; bus.a_stream = pack3(1, 2, 3);
    rst_n = 1'b0;
    step(2);
    total++; if (bus.w_ready !== 1'b1) begin bad++; $display("FAIL reset_w_ready got=%b want=1", bus.w_ready); end
    total++; if (bus.a_ready !== 1'b0) begin bad++; $display("FAIL reset_a_ready got=%b want=0", bus.a_ready); end
    total++; if (bus.y_valid !== 1'b0) begin bad++; $display("FAIL reset_y_valid got=%b want=0", bus.y_valid); end
    total++; if (bus.y_stream !== '0) begin bad++; $display("FAIL reset_y_stream got=%h want=0", bus.y_stream); end
    rst_n = 1'b1;
    step(1);
    total++; if (bus.a_ready !== 1'b0) begin bad++; $display("FAIL empty_a_ready got=%b want=0", bus.a_ready); end
    bus.a_valid = 1'b0;
    step(2);
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_identity();
    bit acc;
    w_rows[0] = pack3(1, 0, 0); w_rows[1] = pack3(0, 1, 0); w_rows[2] = pack3(0, 0, 1);
    load_w();
    #1;
    total++; if (bus.a_ready !== 1'b1) begin bad++; $display("FAIL ready_after_load got=%b want=1", bus.a_ready); end
    send_vec(pack3(1, 2, 3), ypack3(1, 2, 3), acc);
    step(LAT + 3);
    total++; if (obs_q.size() != 1 || exp_q.size() != 1) begin bad++; $display("FAIL identity_count got=%0d want=1", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i].cyc != exp_q[i].cyc || obs_q[i].y !== exp_q[i].y) begin
        bad++; $display("FAIL identity[%0d] got cyc=%0d y=%h want cyc=%0d y=%h", i, obs_q[i].cyc, obs_q[i].y, exp_q[i].cyc, exp_q[i].y);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_matrix();
    bit acc;
    w_rows[0] = pack3(1, 2, 3); w_rows[1] = pack3(4, 5, 6); w_rows[2] = pack3(7, 8, 9);
    load_w();
    send_vec(pack3(1, 1, 1), ypack3(12, 15, 18), acc);
    send_vec(pack3(1, 0, 0), ypack3(1, 2, 3), acc);
    send_vec(pack3(0, 0, 2), ypack3(14, 16, 18), acc);
    step(LAT + 3);
    total++; if (obs_q.size() != 3 || exp_q.size() != 3) begin bad++; $display("FAIL matrix_count got=%0d want=3", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i].cyc != exp_q[i].cyc || obs_q[i].y !== exp_q[i].y) begin
        bad++; $display("FAIL matrix[%0d] got cyc=%0d y=%h want cyc=%0d y=%h", i, obs_q[i].cyc, obs_q[i].y, exp_q[i].cyc, exp_q[i].y);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_extreme();
    bit acc;
    w_rows[0] = pack3(255, 255, 255); w_rows[1] = w_rows[0]; w_rows[2] = w_rows[0];
`ifdef SYSTOLIC_SIGNED_EN
    load_w();
    send_vec(pack3(1, 2, 3), ypack3(-6, -6, -6), acc);
    send_vec(pack3(255, 255, 255), ypack3(3, 3, 3), acc);
`else
    load_w();
    send_vec(pack3(255, 255, 255), ypack3(195075, 195075, 195075), acc);
    send_vec(pack3(1, 2, 3), ypack3(1530, 1530, 1530), acc);
`endif
    step(LAT + 3);
    total++; if (obs_q.size() != 2 || exp_q.size() != 2) begin bad++; $display("FAIL extreme_count got=%0d want=2", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i].cyc != exp_q[i].cyc || obs_q[i].y !== exp_q[i].y) begin
        bad++; $display("FAIL extreme[%0d] got cyc=%0d y=%h want cyc=%0d y=%h", i, obs_q[i].cyc, obs_q[i].y, exp_q[i].cyc, exp_q[i].y);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    bit acc;
    logic [VW-1:0] v;
    for (int r = 0; r < S; r++) w_rows[r] = VW'($urandom);
    load_w();
    for (int i = 0; i < 30; i++) begin
      v = VW'($urandom);
      if ($urandom_range(0, 3) != 0) send_vec(v, ref_y(v), acc);
      else step(1);
    end
    step(LAT + 3);
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i].cyc != exp_q[i].cyc || obs_q[i].y !== exp_q[i].y) begin
        bad++; $display("FAIL b2b[%0d] got cyc=%0d y=%h want cyc=%0d y=%h", i, obs_q[i].cyc, obs_q[i].y, exp_q[i].cyc, exp_q[i].y);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reload();
    bit acc;
    int nacc, t4, c0, n;
    logic [VW-1:0] v;
    for (int r = 0; r < S; r++) w_rows[r] = VW'($urandom);
    load_w();
    nacc = 0;
    for (int i = 0; i < 4; i++) begin
      v = VW'($urandom);
      send_vec(v, ref_y(v), acc);
      if (acc) nacc++;
    end
    t4 = cyc;
    total++; if (nacc != 4) begin bad++; $display("FAIL reload_accepts got=%0d want=4", nacc); end
    for (int r = 0; r < S; r++) w_rows[r] = VW'($urandom);
    bus.w_valid = 1'b1; bus.w_stream = w_rows[0];
    bus.a_valid = 1'b1; bus.a_stream = VW'($urandom);
    #1;
    total++; if (bus.a_ready !== 1'b0) begin bad++; $display("FAIL reload_a_ready_drop got=%b want=0", bus.a_ready); end
    total++; if (bus.w_ready !== 1'b0) begin bad++; $display("FAIL reload_w_ready_busy got=%b want=0", bus.w_ready); end
    n = 0;
    while (n < 20) begin
      step(1);
      n++;
      total++;
      if (bus.w_ready !== (cyc >= t4 + LAT)) begin
        bad++; $display("FAIL reload_w_ready cyc=%0d got=%b want=%b", cyc, bus.w_ready, (cyc >= t4 + LAT));
      end
      if (bus.w_ready === 1'b1) break;
    end
    bus.a_valid = 1'b0;
    c0 = cyc;
    load_w();
    total++; if (cyc - c0 != S) begin bad++; $display("FAIL reload_beats got=%0d cycles want=%0d", cyc - c0, S); end
    #1;
    total++; if (bus.a_ready !== 1'b1) begin bad++; $display("FAIL reload_a_ready_back got=%b want=1", bus.a_ready); end
    v = VW'($urandom);
    send_vec(v, ref_y(v), acc);
    step(LAT + 3);
    total++; if (obs_q.size() != 5 || exp_q.size() != 5) begin bad++; $display("FAIL reload_count got=%0d want=5", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i].cyc != exp_q[i].cyc || obs_q[i].y !== exp_q[i].y) begin
        bad++; $display("FAIL reload[%0d] got cyc=%0d y=%h want cyc=%0d y=%h", i, obs_q[i].cyc, obs_q[i].y, exp_q[i].cyc, exp_q[i].y);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_pause_reset();
    bit acc;
    logic [VW-1:0] v;
    rst_n = 1'b0; step(1); rst_n = 1'b1;
    for (int r = 0; r < S; r++) w_rows[r] = VW'($urandom);
    bus.w_valid = 1'b1; bus.w_stream = w_rows[0];
    step(1);
    bus.w_valid = 1'b0; bus.w_stream = '0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      total++; if (bus.w_ready !== 1'b1 || bus.a_ready !== 1'b0) begin
        bad++; $display("FAIL pause_hold[%0d] got w_ready=%b a_ready=%b want 1/0", i, bus.w_ready, bus.a_ready);
      end
    end
    for (int k = 1; k < S; k++) begin
      bus.w_valid = 1'b1; bus.w_stream = w_rows[k];
      #1;
      total++; if (bus.w_ready !== 1'b1) begin bad++; $display("FAIL pause_resume_w_ready row=%0d got=%b want=1", k, bus.w_ready); end
      step(1);
    end
    bus.w_valid = 1'b0;
    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++) wm[r][c] = int'(w_rows[r][(S-c)*D-1 -: D]);
    for (int i = 0; i < 3; i++) begin
      v = VW'($urandom);
      send_vec(v, ref_y(v), acc);
    end
    step(LAT + 3);
    total++; if (obs_q.size() != 3 || exp_q.size() != 3) begin bad++; $display("FAIL pause_count got=%0d want=3", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i].cyc != exp_q[i].cyc || obs_q[i].y !== exp_q[i].y) begin
        bad++; $display("FAIL pause[%0d] got cyc=%0d y=%h want cyc=%0d y=%h", i, obs_q[i].cyc, obs_q[i].y, exp_q[i].cyc, exp_q[i].y);
      end
    end
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 3; i++) send_vec(VW'($urandom), '0, acc);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    obs_q.delete(); exp_q.delete();
    total++; if (bus.y_valid !== 1'b0 || bus.y_stream !== '0) begin
      bad++; $display("FAIL midreset_y got valid=%b y=%h want 0/0", bus.y_valid, bus.y_stream);
    end
    total++; if (bus.a_ready !== 1'b0 || bus.w_ready !== 1'b1) begin
      bad++; $display("FAIL midreset_ready got a_ready=%b w_ready=%b want 0/1", bus.a_ready, bus.w_ready);
    end
    step(LAT + 3);
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL stale_results got=%0d want=0", obs_q.size()); end
    total++; if (bus.y_stream !== '0) begin bad++; $display("FAIL stale_y_stream got=%h want=0", bus.y_stream); end
  endtask

  initial begin
    bus.w_valid = 1'b0; bus.w_stream = '0; bus.a_valid = 1'b0; bus.a_stream = '0;
    test_reset();
    test_identity();
    test_matrix();
    test_extreme();
    test_back_to_back();
    test_reload();
    test_pause_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
